// File: rtl/knn_pkg.sv
// knn_pkg: shared controller state encoding and default widths for the k-NN top-K feeder.
package knn_pkg;
   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_TAG_WIDTH     = 32;
   localparam int DEF_K             = 8;
   localparam int DEF_SETTLE_CYCLES = 3;

   typedef enum logic [3:0] {
      IDLE, ACCEPT, INSERT, EVICT, EVICT_WAIT, SETTLE, DRAIN, DRAIN_WAIT, HOLD, DONE
   } fsm_state_t;
endpackage

// File: rtl/settle_counter.sv
// settle_counter: loadable down-counter that parks at zero and flags it.
module settle_counter #(
   parameter int W = 2
)(
   input  logic         clk_in,
   input  logic         rst_n_in,
   input  logic         load_in,
   input  logic [W-1:0] load_val_in,
   output logic         zero_out
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in)          r_cnt <= '0;
      else if (load_in)       r_cnt <= load_val_in;
      else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);

   assign zero_out = r_cnt == '0;
endmodule

// File: rtl/knn_topk_feeder.sv
// knn_topk_feeder: keeps the K smallest-tag candidates in a priority queue, then drains them nearest-first.
module knn_topk_feeder
   import knn_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
   parameter int K             = DEF_K,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
)(
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   start_in,
   input  logic                   in_valid_in,
   output logic                   in_ready_out,
   input  logic [DATA_WIDTH-1:0]  in_data_in,
   input  logic [TAG_WIDTH-1:0]   in_tag_in,
   input  logic                   in_last_in,
   output logic                   out_valid_out,
   input  logic                   out_ready_in,
   output logic [DATA_WIDTH-1:0]  out_data_out,
   output logic [TAG_WIDTH-1:0]   out_tag_out,
   output logic [$clog2(K):0]     out_rank_out,
   output logic                   out_last_out,
   output logic                   done_out,
   output logic                   err_out,
   output logic                   q_enq_out,
   output logic [DATA_WIDTH-1:0]  q_enq_data_out,
   output logic [TAG_WIDTH-1:0]   q_enq_tag_out,
   output logic                   q_deq_smallest_out,
   output logic                   q_deq_largest_out,
   input  logic                   q_valid_in,
   input  logic [DATA_WIDTH-1:0]  q_data_in,
   input  logic [TAG_WIDTH-1:0]   q_tag_in,
   input  logic [TAG_WIDTH-1:0]   q_max_tag_in,
   input  logic                   q_empty_in
);
   localparam int CW = $clog2(K) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES) + 1;

   fsm_state_t            r_state, w_next, r_ret;
   logic [CW-1:0]         r_count, r_rank;
   logic [DATA_WIDTH-1:0] r_data, r_out_data;
   logic [TAG_WIDTH-1:0]  r_tag, r_out_tag;
   logic                  r_last, r_err;
   logic                  w_in_hs, w_out_hs, w_start_ok, w_full, w_evict, w_settle_ld, w_settle_zero;

   assign w_in_hs     = r_state == ACCEPT && in_valid_in;
   assign w_out_hs    = r_state == HOLD && out_ready_in;
   assign w_start_ok  = r_state == IDLE && start_in && q_empty_in;
   assign w_full      = r_count >= CW'(K);
   assign w_evict     = in_tag_in < q_max_tag_in;
   // The counter starts on the cycle that ends an operation, so SETTLE itself lasts SETTLE_CYCLES cycles.
   assign w_settle_ld = r_state == INSERT || (r_state == EVICT_WAIT && q_valid_in) || w_out_hs;

   settle_counter #(.W(SW)) u_settle (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .load_in     (w_settle_ld),
      .load_val_in (SW'(SETTLE_CYCLES - 1)),
      .zero_out    (w_settle_zero)
   );

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) r_state <= IDLE;
      else           r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       w_next = w_start_ok ? ACCEPT : IDLE;
         ACCEPT:     if (in_valid_in) w_next = !w_full ? INSERT : w_evict ? EVICT : in_last_in ? DRAIN : ACCEPT;
         INSERT:     w_next = SETTLE;
         EVICT:      w_next = EVICT_WAIT;
         EVICT_WAIT: if (q_valid_in) w_next = SETTLE;
         SETTLE:     if (w_settle_zero) w_next = r_ret;
         DRAIN:      w_next = r_count == '0 ? DONE : DRAIN_WAIT;
         DRAIN_WAIT: if (q_valid_in) w_next = HOLD;
         HOLD:       if (out_ready_in) w_next = SETTLE;
         DONE:       w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready_out       = r_state == ACCEPT;
      q_enq_out          = r_state == INSERT;
      q_deq_largest_out  = r_state == EVICT;
      q_deq_smallest_out = r_state == DRAIN && r_count != '0;
      out_valid_out      = r_state == HOLD;
      out_last_out       = r_state == HOLD && r_count == CW'(1);
      done_out           = r_state == DONE;
   end

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         r_ret      <= IDLE;
         r_count    <= '0;
         r_rank     <= '0;
         r_data     <= '0;
         r_tag      <= '0;
         r_last     <= 1'b0;
         r_out_data <= '0;
         r_out_tag  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_err   <= 1'b0;
            r_count <= '0;
            r_rank  <= '0;
         end else if (r_state == IDLE && start_in) r_err <= 1'b1;
         if (w_in_hs) begin
            r_data <= in_data_in;
            r_tag  <= in_tag_in;
            r_last <= in_last_in;
         end
         // Evict followed by insert leaves count unchanged because the insert sees a full count.
         if (r_state == INSERT) begin
            r_ret <= r_last ? DRAIN : ACCEPT;
            if (!w_full) r_count <= r_count + CW'(1);
         end
         if (r_state == EVICT_WAIT && q_valid_in) r_ret <= INSERT;
         if (r_state == DRAIN_WAIT && q_valid_in) begin
            r_out_data <= q_data_in;
            r_out_tag  <= q_tag_in;
         end
         if (w_out_hs) begin
            r_count <= r_count - CW'(1);
            r_rank  <= r_rank + CW'(1);
            r_ret   <= r_count > CW'(1) ? DRAIN : DONE;
         end
         if (r_state == DONE) r_rank <= '0;
      end

   assign out_data_out   = r_out_data;
   assign out_tag_out    = r_out_tag;
   assign out_rank_out   = r_rank;
   assign err_out        = r_err;
   assign q_enq_data_out = r_data;
   assign q_enq_tag_out  = r_tag;
endmodule
